// File: rtl/comp_frame_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : comp_frame_tx
// Description : Frames 48-bit payload words into a continuous stream of
//               4-word frames for a GTX 8b10b transmitter. Word 0 is a K
//               comma (BC normal, FC latency trigger), words 1..3 carry the
//               payload LSW first. Frames repeat back to back. A frame with
//               no accepted data is an idle frame.
//
// Ports       : CMP_TX_CLK160  in   1   transmit user clock (rising edge)
//               RST            in   1   synchronous active-high reset
//               SEND_DATA      in   48  payload word to frame
//               SEND_VALID     in   1   SEND_DATA valid
//               SEND_READY     out  1   high while FRAME_PHASE==3
//               LTNCY_TRIG     in   1   latency-trigger comma request
//               TX_DATA        out  16  word to 8b10b encoder
//               TX_CHARISK     out  2   per-byte K flags
//               FRAME_PHASE    out  2   0 = comma, 1..3 = payload
//               TRIG_SENT      out  1   pulse with an FC comma word
//               FRAME_CNT      out  16  accepted data frames (wraps)
//
// Build macro : COMP_TX_PRBS_EN -- idle payload taken from a 48-bit LFSR
//               seeded with START_PATTERN; otherwise idle payload is zero.
//
// Revision    : 1.0 - initial release
// ============================================================================
module comp_frame_tx #(
  parameter logic [47:0] START_PATTERN = 48'hFFFFFF000000
) (
  input  logic        CMP_TX_CLK160,
  input  logic        RST,
  input  logic [47:0] SEND_DATA,
  input  logic        SEND_VALID,
  output logic        SEND_READY,
  input  logic        LTNCY_TRIG,
  output logic [15:0] TX_DATA,
  output logic [1:0]  TX_CHARISK,
  output logic [1:0]  FRAME_PHASE,
  output logic        TRIG_SENT,
  output logic [15:0] FRAME_CNT
);

  localparam logic [7:0] c_K_BC = 8'hBC;
  localparam logic [7:0] c_K_FC = 8'hFC;

  typedef enum logic [1:0] {
    PH_COMMA = 2'd0,
    PH_W1    = 2'd1,
    PH_W2    = 2'd2,
    PH_W3    = 2'd3
  } phase_t;

  phase_t      r_phase;
  logic        r_ready;
  logic [15:0] r_tx_data;
  logic [1:0]  r_tx_k;
  logic        r_trig_sent;
  logic        r_pend;
  logic [47:0] r_hold;
  logic [15:0] r_frame_cnt;

  logic        w_xfer;
  logic        w_trig_now;
  logic [47:0] w_idle_payload;

  // READY is only ever high in phase 3, so a transfer always lands on the
  // edge that loads word 0.
  assign w_xfer     = SEND_VALID & r_ready;
  // A trigger arriving on the word-0 edge itself is honoured immediately.
  assign w_trig_now = r_pend | LTNCY_TRIG;

`ifdef COMP_TX_PRBS_EN
  logic [47:0] r_lfsr;
  logic [47:0] w_lfsr_next;

  assign w_lfsr_next    = {r_lfsr[46:0], r_lfsr[47] ^ r_lfsr[46] ^ r_lfsr[20] ^ r_lfsr[19]};
  assign w_idle_payload = r_lfsr;

  always_ff @(posedge CMP_TX_CLK160) begin
    if (RST) begin
      r_lfsr <= START_PATTERN;
    end else if ((r_phase == PH_W3) && !w_xfer) begin
      // Advance once per idle frame, after its payload has been captured.
      r_lfsr <= w_lfsr_next;
    end
  end
`else
  // The seed has no role in this build; masking it keeps the parameter
  // referenced while the idle payload reduces to a constant zero.
  assign w_idle_payload = START_PATTERN & 48'h0;
`endif

  always_ff @(posedge CMP_TX_CLK160) begin
    if (RST) begin
      r_phase     <= PH_W3;
      r_ready     <= 1'b0;
      r_tx_data   <= 16'h0000;
      r_tx_k      <= 2'b00;
      r_trig_sent <= 1'b0;
      r_pend      <= 1'b0;
      r_hold      <= 48'h0;
      r_frame_cnt <= 16'h0000;
    end else begin
      r_trig_sent <= 1'b0;
      // Registered READY lines up with phase 3 one edge later.
      r_ready     <= (r_phase == PH_W2);
      r_pend      <= r_pend | LTNCY_TRIG;

      case (r_phase)
        PH_W3: begin
          r_phase     <= PH_COMMA;
          r_tx_data   <= {8'h00, (w_trig_now ? c_K_FC : c_K_BC)};
          r_tx_k      <= 2'b01;
          r_trig_sent <= w_trig_now;
          r_pend      <= 1'b0;
          if (w_xfer) begin
            r_hold      <= SEND_DATA;
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end else begin
            r_hold      <= w_idle_payload;
          end
        end
        PH_COMMA: begin
          r_phase   <= PH_W1;
          r_tx_data <= r_hold[15:0];
          r_tx_k    <= 2'b00;
        end
        PH_W1: begin
          r_phase   <= PH_W2;
          r_tx_data <= r_hold[31:16];
          r_tx_k    <= 2'b00;
        end
        PH_W2: begin
          r_phase   <= PH_W3;
          r_tx_data <= r_hold[47:32];
          r_tx_k    <= 2'b00;
        end
      endcase
    end
  end

  assign SEND_READY  = r_ready;
  assign TX_DATA     = r_tx_data;
  assign TX_CHARISK  = r_tx_k;
  assign FRAME_PHASE = r_phase;
  assign TRIG_SENT   = r_trig_sent;
  assign FRAME_CNT   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_comp_frame_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_comp_frame_tx
// Description : Directed self-checking bench for comp_frame_tx. Walks the
//               frame stream word by word against hand-computed values.
// Revision    : 1.1 - checking task, watchdog
// ============================================================================
module tb_comp_frame_tx;

    localparam logic [47:0] c_START_PATTERN = 48'hFFFFFF000000;
    localparam int          c_TIMEOUT_NS    = 100000;

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic [47:0] r_send_data;
    logic        r_send_valid;
    logic        w_send_ready;
    logic        r_ltncy_trig;
    logic [15:0] w_tx_data;
    logic [1:0]  w_tx_charisk;
    logic [1:0]  w_frame_phase;
    logic        w_trig_sent;
    logic [15:0] w_frame_cnt;

    int r_checks = 0;
    int r_errors = 0;
    logic r_done = 1'b0;

    logic [47:0] r_exp_lfsr = c_START_PATTERN;
    logic [47:0] r_p;

    always #5 r_clk = ~r_clk;

    comp_frame_tx dut (
        .CMP_TX_CLK160 (r_clk),
        .RST           (r_rst),
        .SEND_DATA     (r_send_data),
        .SEND_VALID    (r_send_valid),
        .SEND_READY    (w_send_ready),
        .LTNCY_TRIG    (r_ltncy_trig),
        .TX_DATA       (w_tx_data),
        .TX_CHARISK    (w_tx_charisk),
        .FRAME_PHASE   (w_frame_phase),
        .TRIG_SENT     (w_trig_sent),
        .FRAME_CNT     (w_frame_cnt)
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    task automatic next_idle(output logic [47:0] pl);
`ifdef COMP_TX_PRBS_EN
        pl         = r_exp_lfsr;
        r_exp_lfsr = {r_exp_lfsr[46:0], r_exp_lfsr[47] ^ r_exp_lfsr[46] ^ r_exp_lfsr[20] ^ r_exp_lfsr[19]};
`else
        pl = 48'h0;
`endif
    endtask

    // Checks one full frame. After each word the trigger input takes tp[i];
    // after word 0 the data/valid inputs take nd/nv.
    task automatic frame(input string tag, input logic [7:0] kc, input logic [47:0] pl,
                         input logic trig, input logic [3:0] tp, input logic [47:0] nd,
                         input logic nv, input logic [15:0] cnt);
        step();
        chk({tag, "_w0_data"},  w_tx_data,     {8'h00, kc});
        chk({tag, "_w0_k"},     w_tx_charisk,  2'b01);
        chk({tag, "_w0_phase"}, w_frame_phase, 2'd0);
        chk({tag, "_w0_trig"},  w_trig_sent,   trig);
        chk({tag, "_w0_ready"}, w_send_ready,  1'b0);
        r_send_data  = nd;
        r_send_valid = nv;
        r_ltncy_trig = tp[0];
        step();
        chk({tag, "_w1_data"},  w_tx_data,     pl[15:0]);
        chk({tag, "_w1_k"},     w_tx_charisk,  2'b00);
        chk({tag, "_w1_phase"}, w_frame_phase, 2'd1);
        chk({tag, "_w1_trig"},  w_trig_sent,   1'b0);
        chk({tag, "_w1_ready"}, w_send_ready,  1'b0);
        r_ltncy_trig = tp[1];
        step();
        chk({tag, "_w2_data"},  w_tx_data,     pl[31:16]);
        chk({tag, "_w2_k"},     w_tx_charisk,  2'b00);
        chk({tag, "_w2_phase"}, w_frame_phase, 2'd2);
        chk({tag, "_w2_ready"}, w_send_ready,  1'b0);
        r_ltncy_trig = tp[2];
        step();
        chk({tag, "_w3_data"},  w_tx_data,     pl[47:32]);
        chk({tag, "_w3_k"},     w_tx_charisk,  2'b00);
        chk({tag, "_w3_phase"}, w_frame_phase, 2'd3);
        chk({tag, "_w3_ready"}, w_send_ready,  1'b1);
        chk({tag, "_cnt"},      w_frame_cnt,   cnt);
        r_ltncy_trig = tp[3];
    endtask

    initial begin
        #(c_TIMEOUT_NS);
        if (!r_done) begin
            r_errors++;
            $error("FAIL timeout: stimulus did not complete within %0d ns", c_TIMEOUT_NS);
            $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
            $finish;
        end
    end

    initial begin
        r_rst        = 1'b1;
        r_send_data  = 48'h0;
        r_send_valid = 1'b0;
        r_ltncy_trig = 1'b0;
        repeat (3) step();
        chk("rst_data",  w_tx_data,     16'h0000);
        chk("rst_k",     w_tx_charisk,  2'b00);
        chk("rst_phase", w_frame_phase, 2'd3);
        chk("rst_ready", w_send_ready,  1'b0);
        chk("rst_trig",  w_trig_sent,   1'b0);
        chk("rst_cnt",   w_frame_cnt,   16'h0000);
        r_rst = 1'b0;

        // Idle frames; valid raised while READY is low must not be taken.
        next_idle(r_p);
        frame("f1", 8'hBC, r_p, 1'b0, 4'b0000, 48'h0, 1'b0, 16'd0);
        next_idle(r_p);
        frame("f2", 8'hBC, r_p, 1'b0, 4'b0000, 48'h123456789ABC, 1'b1, 16'd0);
        // Data frames; f4 changes SEND_DATA mid-frame and pulses trigger in word 2.
        frame("f3", 8'hBC, 48'h123456789ABC, 1'b0, 4'b0000, 48'h123456789ABC, 1'b1, 16'd1);
        frame("f4", 8'hBC, 48'h123456789ABC, 1'b0, 4'b0100, 48'hCAFEBABE0001, 1'b1, 16'd2);
        // Two trigger pulses within f5 coalesce into the single FC of f6.
        frame("f5", 8'hFC, 48'hCAFEBABE0001, 1'b1, 4'b0101, 48'hCAFEBABE0001, 1'b1, 16'd3);
        frame("f6", 8'hFC, 48'hCAFEBABE0001, 1'b1, 4'b0000, 48'h0, 1'b0, 16'd4);
        next_idle(r_p);
        frame("f7", 8'hBC, r_p, 1'b0, 4'b0000, 48'h111122223333, 1'b1, 16'd4);

        // Counter at its top value: the next transfer wraps it.
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        // Trigger held only on the next word-0 edge takes effect immediately.
        frame("f8", 8'hBC, 48'h111122223333, 1'b0, 4'b1000, 48'h0, 1'b0, 16'd0);
        next_idle(r_p);
        frame("f9", 8'hFC, r_p, 1'b1, 4'b0000, 48'h0, 1'b0, 16'd0);

        // Abort an idle frame at phase 2 with a trigger raised during reset.
        next_idle(r_p);
        step();
        chk("ab_w0_data", w_tx_data, 16'h00BC);
        step();
        chk("ab_w1_data", w_tx_data, r_p[15:0]);
        step();
        chk("ab_w2_phase", w_frame_phase, 2'd2);
        r_rst        = 1'b1;
        r_ltncy_trig = 1'b1;
        step();
        chk("ab_rst_data",  w_tx_data,     16'h0000);
        chk("ab_rst_k",     w_tx_charisk,  2'b00);
        chk("ab_rst_phase", w_frame_phase, 2'd3);
        chk("ab_rst_ready", w_send_ready,  1'b0);
        chk("ab_rst_trig",  w_trig_sent,   1'b0);
        chk("ab_rst_cnt",   w_frame_cnt,   16'h0000);
        r_rst        = 1'b0;
        r_ltncy_trig = 1'b0;
        r_exp_lfsr   = c_START_PATTERN;
        next_idle(r_p);
        frame("f10", 8'hBC, r_p, 1'b0, 4'b0000, 48'h0, 1'b0, 16'd0);

        r_done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        if (r_errors == 0) begin
            $display("TEST PASSED");
        end else begin
            $display("TEST FAILED");
        end
        $finish;
    end

endmodule
`default_nettype wire
